pio_arbiter: RTL and testbench

PIO_ARBITER -- requirements
Module: pio_arbiter

---
 rtl/pio_arbiter_pkg.sv | 20 ++
 rtl/pio_rr_grant.sv | 26 ++
 rtl/pio_arbiter.sv | 157 +++++++++++++++
 tb/tb_pio_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_arbiter_pkg.sv
// pio_arbiter_pkg
// Shared definitions for the two-master PIO arbiter: bus widths, the
// arbiter state encoding and the register offsets of the PIO slave.
package pio_arbiter_pkg;

   localparam int ADDR_W = 3;
   localparam int DATA_W = 32;

   typedef enum logic {
      IDLE   = 1'b0,
      RDWAIT = 1'b1
   } state_e;

   // PIO slave register map (word offsets)
   localparam logic [ADDR_W-1:0] PIO_DATA = 3'd0;
   localparam logic [ADDR_W-1:0] PIO_DIR  = 3'd1;
   localparam logic [ADDR_W-1:0] PIO_SET  = 3'd4;
   localparam logic [ADDR_W-1:0] PIO_CLR  = 3'd5;

endpackage

// File: rtl/pio_rr_grant.sv
// pio_rr_grant
// Combinational two-way round-robin grant.
// Ports:
//   req_i[1:0]    pending requesters
//   last_grant_i  index of the requester granted most recently
//   mask_i[1:0]   requesters currently allowed to win (lock ownership)
//   grant_o[1:0]  one-hot grant, zero when nothing eligible
module pio_rr_grant (
   input  logic [1:0] req_i,
   input  logic       last_grant_i,
   input  logic [1:0] mask_i,
   output logic [1:0] grant_o
);

   logic [1:0] elig;

   always_comb begin
      elig    = req_i & mask_i;
      grant_o = elig;
      // On a tie the requester that did not win last time goes next.
      if (elig == 2'b11) begin
         grant_o = last_grant_i ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/pio_arbiter.sv
// pio_arbiter
// Arbitrates two Avalon-style masters onto one PIO slave. Writes are
// issued and completed in the grant cycle; reads hold the arbiter in
// RDWAIT for one cycle and return registered data two cycles after
// acceptance.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   mN_address/read/write/writedata  requester N command (N = 0,1)
//   mN_waitrequest                 low only in the cycle N's command is issued
//   mN_readdata/readdatavalid      registered read return to requester N
//   s_address/chipselect/write_n/writedata  PIO slave command
//   s_readdata                     PIO slave read data (cycle after chipselect)
//   mN_lock                        only with PIO_ARBITER_LOCK_EN: lock request
// Configuration: define PIO_ARBITER_LOCK_EN to add bus locking.
module pio_arbiter
   import pio_arbiter_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_writedata,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,
`ifdef PIO_ARBITER_LOCK_EN
   input  logic              m0_lock,
   input  logic              m1_lock,
`endif
   output logic [ADDR_W-1:0] s_address,
   output logic              s_chipselect,
   output logic              s_write_n,
   output logic [DATA_W-1:0] s_writedata,
   input  logic [DATA_W-1:0] s_readdata
);

   state_e            state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic              rd_owner_q, rd_owner_d;
   logic              m0_rdv_q, m1_rdv_q;
   logic [DATA_W-1:0] m0_rdata_q, m1_rdata_q;
   logic [1:0]        req, allow, grant;
   logic              issue, win, win_write;

   // Requests are only considered in IDLE; RDWAIT never issues.
   assign req       = {m1_read | m1_write, m0_read | m0_write} & {2{state_q == IDLE}};
   assign issue     = |grant;
   assign win       = grant[1];
   assign win_write = win ? m1_write : m0_write;

   pio_rr_grant u_grant (
      .req_i        (req),
      .last_grant_i (last_grant_q),
      .mask_i       (allow),
      .grant_o      (grant)
   );

`ifdef PIO_ARBITER_LOCK_EN
   logic own_vld_q, own_vld_d, own_id_q, own_id_d;
   logic win_lock, own_cmd, own_lock;

   always_comb begin
      own_vld_d = own_vld_q;
      own_id_d  = own_id_q;
      win_lock  = win ? m1_lock : m0_lock;
      own_cmd   = own_id_q ? (m1_read | m1_write) : (m0_read | m0_write);
      own_lock  = own_id_q ? m1_lock : m0_lock;
      if (issue) begin
         if (win_lock) begin
            own_vld_d = 1'b1;
            own_id_d  = win;
         end else if (own_vld_q && (win == own_id_q)) begin
            own_vld_d = 1'b0;
         end
      end else if ((state_q == IDLE) && own_vld_q && !own_lock && !own_cmd) begin
         // Owner went quiet with its lock released.
         own_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         own_vld_q <= 1'b0;
         own_id_q  <= 1'b0;
      end else begin
         own_vld_q <= own_vld_d;
         own_id_q  <= own_id_d;
      end
   end

   assign allow = !own_vld_q ? 2'b11 : (own_id_q ? 2'b10 : 2'b01);
`else
   assign allow = 2'b11;
`endif

   always_comb begin
      s_chipselect   = 1'b0;
      s_write_n      = 1'b1;
      s_address      = '0;
      s_writedata    = '0;
      m0_waitrequest = 1'b1;
      m1_waitrequest = 1'b1;
      state_d        = state_q;
      last_grant_d   = last_grant_q;
      rd_owner_d     = rd_owner_q;
      if (state_q == RDWAIT) begin
         state_d = IDLE;
      end else if (issue) begin
         s_chipselect = 1'b1;
         s_write_n    = ~win_write;
         s_address    = win ? m1_address : m0_address;
         s_writedata  = win ? m1_writedata : m0_writedata;
         if (win) m1_waitrequest = 1'b0;
         else     m0_waitrequest = 1'b0;
         last_grant_d = win;
         if (!win_write) begin
            state_d    = RDWAIT;
            rd_owner_d = win;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         rd_owner_q   <= 1'b0;
         m0_rdv_q     <= 1'b0;
         m1_rdv_q     <= 1'b0;
         m0_rdata_q   <= '0;
         m1_rdata_q   <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         rd_owner_q   <= rd_owner_d;
         // Slave data is valid during RDWAIT; capture it for the owner.
         m0_rdv_q     <= (state_q == RDWAIT) && !rd_owner_q;
         m1_rdv_q     <= (state_q == RDWAIT) && rd_owner_q;
         if ((state_q == RDWAIT) && !rd_owner_q) m0_rdata_q <= s_readdata;
         if ((state_q == RDWAIT) && rd_owner_q)  m1_rdata_q <= s_readdata;
      end
   end

   assign m0_readdata      = m0_rdata_q;
   assign m1_readdata      = m1_rdata_q;
   assign m0_readdatavalid = m0_rdv_q;
   assign m1_readdatavalid = m1_rdv_q;

endmodule

// File: tb/tb_pio_arbiter.sv
module tb_pio_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  m0_address, m1_address, s_address;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [31:0] m0_writedata, m1_writedata, s_writedata, s_readdata;
   logic        m0_waitrequest, m1_waitrequest;
   logic [31:0] m0_readdata, m1_readdata;
   logic        m0_readdatavalid, m1_readdatavalid;
   logic        s_chipselect, s_write_n;
`ifdef PIO_ARBITER_LOCK_EN
   logic        m0_lock, m1_lock;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pio_arbiter dut (
      .clk              (clk),
      .reset            (reset),
      .m0_address       (m0_address),
      .m0_read          (m0_read),
      .m0_write         (m0_write),
      .m0_writedata     (m0_writedata),
      .m0_waitrequest   (m0_waitrequest),
      .m0_readdata      (m0_readdata),
      .m0_readdatavalid (m0_readdatavalid),
      .m1_address       (m1_address),
      .m1_read          (m1_read),
      .m1_write         (m1_write),
      .m1_writedata     (m1_writedata),
      .m1_waitrequest   (m1_waitrequest),
      .m1_readdata      (m1_readdata),
      .m1_readdatavalid (m1_readdatavalid),
`ifdef PIO_ARBITER_LOCK_EN
      .m0_lock          (m0_lock),
      .m1_lock          (m1_lock),
`endif
      .s_address        (s_address),
      .s_chipselect     (s_chipselect),
      .s_write_n        (s_write_n),
      .s_writedata      (s_writedata),
      .s_readdata       (s_readdata)
   );

   typedef struct {
      logic        m0r, m0w;
      logic [2:0]  m0a;
      logic [31:0] m0d;
      logic        m1r, m1w;
      logic [2:0]  m1a;
      logic [31:0] m1d;
      logic [31:0] sd;
      logic        cs, wn;
      logic [2:0]  sa;
      logic [31:0] swd;
      logic        w0, w1, v0, v1;
      logic [31:0] rd0, rd1;
   } vec_t;

   localparam int NROW = 18;
   vec_t tbl [NROW];

   function automatic vec_t mk(
      input logic m0r, input logic m0w, input logic [2:0] m0a, input logic [31:0] m0d,
      input logic m1r, input logic m1w, input logic [2:0] m1a, input logic [31:0] m1d,
      input logic [31:0] sd,
      input logic cs, input logic wn, input logic [2:0] sa, input logic [31:0] swd,
      input logic w0, input logic w1, input logic v0, input logic v1,
      input logic [31:0] rd0, input logic [31:0] rd1);
      vec_t v;
      v.m0r = m0r; v.m0w = m0w; v.m0a = m0a; v.m0d = m0d;
      v.m1r = m1r; v.m1w = m1w; v.m1a = m1a; v.m1d = m1d;
      v.sd = sd; v.cs = cs; v.wn = wn; v.sa = sa; v.swd = swd;
      v.w0 = w0; v.w1 = w1; v.v0 = v0; v.v1 = v1; v.rd0 = rd0; v.rd1 = rd1;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string p, input logic cs, input logic wn, input logic [2:0] sa,
                          input logic [31:0] swd, input logic w0, input logic w1,
                          input logic v0, input logic v1, input logic [31:0] rd0,
                          input logic [31:0] rd1);
      chk({p, " s_chipselect"}, 32'(s_chipselect), 32'(cs));
      chk({p, " s_write_n"}, 32'(s_write_n), 32'(wn));
      chk({p, " s_address"}, 32'(s_address), 32'(sa));
      chk({p, " s_writedata"}, s_writedata, swd);
      chk({p, " m0_waitrequest"}, 32'(m0_waitrequest), 32'(w0));
      chk({p, " m1_waitrequest"}, 32'(m1_waitrequest), 32'(w1));
      chk({p, " m0_readdatavalid"}, 32'(m0_readdatavalid), 32'(v0));
      chk({p, " m1_readdatavalid"}, 32'(m1_readdatavalid), 32'(v1));
      chk({p, " m0_readdata"}, m0_readdata, rd0);
      chk({p, " m1_readdata"}, m1_readdata, rd1);
   endtask

   task automatic set_in(input logic m0r, input logic m0w, input logic [2:0] m0a,
                         input logic [31:0] m0d, input logic m1r, input logic m1w,
                         input logic [2:0] m1a, input logic [31:0] m1d, input logic [31:0] sd);
      m0_read = m0r; m0_write = m0w; m0_address = m0a; m0_writedata = m0d;
      m1_read = m1r; m1_write = m1w; m1_address = m1a; m1_writedata = m1d;
      s_readdata = sd;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   // Reference model state for the randomized phase
   bit          m_busy, m_owner, m_last;
   bit          m_rdv0, m_rdv1;
   logic [31:0] m_rd0, m_rd1;

   initial begin
      reset = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef PIO_ARBITER_LOCK_EN
      m0_lock = 1'b0;
      m1_lock = 1'b0;
`endif
      //             m0r m0w a  d           m1r m1w a  d          sd            cs wn sa swd         w0 w1 v0 v1 rd0           rd1
      tbl[0]  = mk(0, 0, 0, 0,            0, 0, 0, 0,           0,            0, 1, 0, 0,          1, 1, 0, 0, 0,            0);
      tbl[1]  = mk(0, 1, 2, 32'h11,       0, 1, 3, 32'h22,      0,            1, 0, 2, 32'h11,     0, 1, 0, 0, 0,            0);
      tbl[2]  = mk(0, 1, 2, 32'h11,       0, 1, 3, 32'h22,      0,            1, 0, 3, 32'h22,     1, 0, 0, 0, 0,            0);
      tbl[3]  = mk(0, 1, 2, 32'h11,       0, 1, 3, 32'h22,      0,            1, 0, 2, 32'h11,     0, 1, 0, 0, 0,            0);
      tbl[4]  = mk(0, 1, 2, 32'h11,       0, 1, 3, 32'h22,      0,            1, 0, 3, 32'h22,     1, 0, 0, 0, 0,            0);
      tbl[5]  = mk(0, 1, 1, 32'hFF,       0, 0, 0, 0,           0,            1, 0, 1, 32'hFF,     0, 1, 0, 0, 0,            0);
      tbl[6]  = mk(0, 0, 0, 0,            1, 0, 1, 0,           0,            1, 1, 1, 0,          1, 0, 0, 0, 0,            0);
      tbl[7]  = mk(0, 1, 4, 32'h33,       0, 0, 0, 0,           32'hFF,       0, 1, 0, 0,          1, 1, 0, 0, 0,            0);
      tbl[8]  = mk(0, 1, 4, 32'h33,       0, 0, 0, 0,           32'hDEAD,     1, 0, 4, 32'h33,     0, 1, 0, 1, 0,            32'hFF);
      tbl[9]  = mk(0, 0, 0, 0,            0, 0, 0, 0,           0,            0, 1, 0, 0,          1, 1, 0, 0, 0,            32'hFF);
      tbl[10] = mk(1, 0, 5, 0,            0, 0, 0, 0,           0,            1, 1, 5, 0,          0, 1, 0, 0, 0,            32'hFF);
      tbl[11] = mk(0, 0, 0, 0,            0, 1, 0, 32'h44,      32'hA5A5,     0, 1, 0, 0,          1, 1, 0, 0, 0,            32'hFF);
      tbl[12] = mk(0, 0, 0, 0,            0, 1, 0, 32'h44,      0,            1, 0, 0, 32'h44,     1, 0, 1, 0, 32'hA5A5,     32'hFF);
      tbl[13] = mk(1, 1, 6, 32'h55,       0, 0, 0, 0,           0,            1, 0, 6, 32'h55,     0, 1, 0, 0, 32'hA5A5,     32'hFF);
      tbl[14] = mk(0, 0, 0, 0,            0, 0, 0, 0,           0,            0, 1, 0, 0,          1, 1, 0, 0, 32'hA5A5,     32'hFF);
      tbl[15] = mk(1, 0, 2, 0,            0, 0, 0, 0,           0,            1, 1, 2, 0,          0, 1, 0, 0, 32'hA5A5,     32'hFF);
      tbl[16] = mk(0, 0, 0, 0,            0, 1, 7, 32'h66,      32'h12345678, 0, 1, 0, 0,          1, 1, 0, 0, 32'hA5A5,     32'hFF);
      tbl[17] = mk(0, 0, 0, 0,            0, 0, 0, 0,           0,            0, 1, 0, 0,          1, 1, 1, 0, 32'h12345678, 32'hFF);

      // Reset state
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk_all("reset", 0, 1, 0, 0, 1, 1, 0, 0, 0, 0);

      // Directed vector table, one row per cycle
      for (int i = 0; i < NROW; i++) begin
         @(posedge clk); #1;
         set_in(tbl[i].m0r, tbl[i].m0w, tbl[i].m0a, tbl[i].m0d,
                tbl[i].m1r, tbl[i].m1w, tbl[i].m1a, tbl[i].m1d, tbl[i].sd);
         @(negedge clk);
         chk_all($sformatf("row%0d", i), tbl[i].cs, tbl[i].wn, tbl[i].sa, tbl[i].swd,
                 tbl[i].w0, tbl[i].w1, tbl[i].v0, tbl[i].v1, tbl[i].rd0, tbl[i].rd1);
      end

      // Reset pulsed while a read waits: read discarded, tie goes to m0
      @(posedge clk); #1;
      set_in(1, 0, 3, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("rstrd accept cs", 32'(s_chipselect), 1);
      @(posedge clk); #1;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 32'hBEEF);
      reset = 1'b1;
      @(negedge clk);
      chk("rstrd rdwait cs", 32'(s_chipselect), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      set_in(0, 1, 6, 32'hA, 0, 1, 7, 32'hB, 0);
      @(negedge clk);
      chk_all("rstrd tie", 1, 0, 6, 32'hA, 0, 1, 0, 0, 0, 0);
      @(posedge clk); #1;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("rstrd no rdv0", 32'(m0_readdatavalid), 0);
      chk("rstrd no rdv1", 32'(m1_readdatavalid), 0);

`ifdef PIO_ARBITER_LOCK_EN
      // Locked read then unlocked write by m0 while m1 keeps requesting
      do_reset();
      set_in(1, 0, 1, 0, 0, 1, 2, 32'h77, 32'h0);
      m0_lock = 1'b1;
      @(negedge clk);
      chk_all("lock c0", 1, 1, 1, 0, 0, 1, 0, 0, 0, 0);
      @(posedge clk); #1;
      set_in(0, 1, 1, 32'h9, 0, 1, 2, 32'h77, 32'h5A);
      m0_lock = 1'b0;
      @(negedge clk);
      chk_all("lock c1", 0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk_all("lock c2", 1, 0, 1, 32'h9, 0, 1, 1, 0, 32'h5A, 0);
      @(posedge clk); #1;
      set_in(0, 0, 0, 0, 0, 1, 2, 32'h77, 0);
      @(negedge clk);
      chk_all("lock c3", 1, 0, 2, 32'h77, 1, 0, 0, 0, 32'h5A, 0);
`endif

      // Randomized phase against the reference model
      do_reset();
      m_busy = 0; m_owner = 0; m_last = 1;
      m_rdv0 = 0; m_rdv1 = 0; m_rd0 = 0; m_rd1 = 0;
      for (int c = 0; c < 400; c++) begin
         int  k0, k1, win;
         bit  rst_now, p0, p1, iss, wwr;
         logic [31:0] swd;
         logic [2:0]  sa;
         @(posedge clk); #1;
         k0 = $urandom_range(0, 3);
         k1 = $urandom_range(0, 3);
         set_in(k0[0], k0[1], 3'($urandom_range(0, 7)), $urandom,
                k1[0], k1[1], 3'($urandom_range(0, 7)), $urandom, $urandom);
         rst_now = ($urandom_range(0, 39) == 0);
         reset   = rst_now;
         @(negedge clk);
         // Expected issue from the arbitration rules
         p0 = !m_busy && (m0_read || m0_write);
         p1 = !m_busy && (m1_read || m1_write);
         win = -1;
         if (p0 && p1) win = m_last ? 0 : 1;
         else if (p0)  win = 0;
         else if (p1)  win = 1;
         iss = (win >= 0);
         wwr = (win == 1) ? m1_write : m0_write;
         sa  = !iss ? 3'd0 : (win == 1) ? m1_address : m0_address;
         swd = !iss ? 32'd0 : (win == 1) ? m1_writedata : m0_writedata;
         chk_all($sformatf("rand%0d", c), iss, !(iss && wwr), sa, swd,
                 !(win == 0), !(win == 1), m_rdv0, m_rdv1, m_rd0, m_rd1);
         // Advance the model across the coming clock edge
         if (rst_now) begin
            m_busy = 0; m_owner = 0; m_last = 1;
            m_rdv0 = 0; m_rdv1 = 0; m_rd0 = 0; m_rd1 = 0;
         end else begin
            m_rdv0 = m_busy && !m_owner;
            m_rdv1 = m_busy && m_owner;
            if (m_rdv0) m_rd0 = s_readdata;
            if (m_rdv1) m_rd1 = s_readdata;
            if (iss) begin
               m_last  = (win == 1);
               m_busy  = !wwr;
               m_owner = (win == 1);
            end else begin
               m_busy = 0;
            end
         end
      end
      reset = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
